// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Wide enough for any supported operand width; users slice to their own width.
   localparam logic [63:0] ALL_ONES = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, try to subtract the divisor.
module div_step #(
   parameter int W = 16
) (
   input  logic [W-1:0] rem_i,
   input  logic         bit_i,
   input  logic [W-1:0] divisor_i,
   output logic [W-1:0] rem_o,
   output logic         q_bit_o
);

   logic [W:0] trial;

   // The trial needs W+1 bits for the compare; the restored or reduced
   // remainder is always below the divisor, so the low W bits carry it exactly.
   always_comb begin
      trial   = {rem_i, bit_i};
      q_bit_o = (trial >= {1'b0, divisor_i});
      rem_o   = q_bit_o ? (trial[W-1:0] - divisor_i) : trial[W-1:0];
   end

endmodule

// File: rtl/div_int.sv
// Iterative unsigned divider: 2W-bit dividend by W-bit divisor, one quotient bit per cycle.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | W restoring iterations in progress
// DONE  | result presented, waiting for out_ready
module div_int
   import div_pkg::*;
#(
   parameter  int DATA_WIDTH = 16,
   localparam int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [2*DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0]   divisor,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   quotient,
   output logic [DATA_WIDTH-1:0]   remainder,
   output logic                    div_zero,
   output logic                    overflow
);

   localparam int W = DATA_WIDTH;
   localparam logic [W-1:0]         ONES_W   = ALL_ONES[W-1:0];
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(W - 1);

   div_state_t           state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [W-1:0]         rem_q, rem_d;
   logic [W-1:0]         shift_q, shift_d;
   logic [W-1:0]         divisor_q, divisor_d;
   logic [W-1:0]         quotient_q, quotient_d;
   logic [W-1:0]         remainder_q, remainder_d;
   logic                 div_zero_q, div_zero_d;
   logic                 overflow_q, overflow_d;

   logic [W-1:0]         step_rem;
   logic                 step_qbit;

   div_step #(.W(W)) u_step (
      .rem_i     (rem_q),
      .bit_i     (shift_q[W-1]),
      .divisor_i (divisor_q),
      .rem_o     (step_rem),
      .q_bit_o   (step_qbit)
   );

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;
   assign overflow  = overflow_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      shift_d     = shift_q;
      divisor_d   = divisor_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
      overflow_d  = overflow_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (divisor == '0) begin
                  quotient_d  = ONES_W;
                  remainder_d = dividend[W-1:0];
                  div_zero_d  = 1'b1;
                  overflow_d  = 1'b0;
                  state_d     = DONE;
               end else if (dividend[2*W-1:W] >= divisor) begin
                  quotient_d  = ONES_W;
                  remainder_d = '0;
                  div_zero_d  = 1'b0;
                  overflow_d  = 1'b1;
                  state_d     = DONE;
               end else begin
                  rem_d     = dividend[2*W-1:W];
                  shift_d   = dividend[W-1:0];
                  divisor_d = divisor;
                  cnt_d     = '0;
                  state_d   = BUSY;
               end
            end
         end

         // Dividend bits leave at the MSB while quotient bits enter at the LSB,
         // so after W steps the shift register holds the quotient.
         BUSY: begin
            rem_d   = step_rem;
            shift_d = {shift_q[W-2:0], step_qbit};
            cnt_d   = cnt_q + CNT_WIDTH'(1);
            if (cnt_q == CNT_LAST) begin
               cnt_d       = '0;
               quotient_d  = {shift_q[W-2:0], step_qbit};
               remainder_d = step_rem;
               div_zero_d  = 1'b0;
               overflow_d  = 1'b0;
               state_d     = DONE;
            end
         end

         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         shift_q     <= '0;
         divisor_q   <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         shift_q     <= shift_d;
         divisor_q   <= divisor_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
         overflow_q  <= overflow_d;
      end
   end

endmodule

// File: doc/div_int.md
Name: div_int

Overview:
- Iterative unsigned integer divider; the inverse of the datapath multiplier.
- Takes a 2W-bit dividend (product width) and a W-bit divisor. Returns a W-bit quotient and a W-bit remainder.
- Restoring algorithm, one quotient bit per cycle.
- Valid/ready handshakes on both sides. Sits after multiplier-normalised stages wherever a scale-back division is needed.

Parameters:
- DATA_WIDTH, 16, operand width W; dividend is 2W, divisor/quotient/remainder are W.
- CNT_WIDTH, $clog2(DATA_WIDTH+1), width of the iteration counter (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  divider can accept operands
- dividend  input  2W  unsigned dividend
- divisor  input  W  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  W  unsigned quotient
- remainder  output  W  unsigned remainder
- div_zero  output  1  divisor was zero
- overflow  output  1  quotient does not fit in W bits

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; counter 0.
  - out_valid=0; quotient, remainder, div_zero and overflow all 0.
  - in_ready=1 once out of reset (in_ready is decoded combinationally from state).
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: in_valid & in_ready at a rising edge. Operands are captured on that edge and are not sampled again.
- Special cases, checked at accept, in priority order:
  - divisor==0 → DONE next edge. quotient=all ones, remainder=dividend[W-1:0], div_zero=1, overflow=0.
  - dividend[2W-1:W] >= divisor → DONE next edge. quotient=all ones, remainder=0, overflow=1, div_zero=0.
  - Otherwise → BUSY with:
    - partial remainder = dividend[2W-1:W];
    - shift register = dividend[W-1:0];
    - counter=0.
- BUSY step, each edge:
  - Form trial = {partial remainder, next dividend MSB} (W+1 bits), then subtract divisor.
  - If non-negative: the difference becomes the new partial remainder and the quotient bit is 1. Otherwise keep the trial and the quotient bit is 0.
  - Quotient bits shift in at the LSB.
  - The counter increments. After the W-th BUSY edge, go to DONE with final quotient and remainder; both flags are 0.
- Latency:
  - Normal case: out_valid rises W+1 edges after the accept edge (accept edge included).
  - Special cases: out_valid rises 1 edge after accept.
- DONE:
  - Outputs held stable while out_ready=0, for any number of cycles.
  - On out_valid & out_ready → IDLE. out_valid drops on that edge; data outputs keep their last value.
- Throughput: one division per W+2 cycles minimum. No overlap: in_ready stays 0 in the DONE state even when out_ready=1.
- in_valid while BUSY or DONE is ignored (not queued).
- Reset mid-BUSY or mid-DONE: the in-flight result is discarded and outputs return to reset values immediately.
- Intermediate subtract must be W+1 bits wide to hold the shifted remainder without loss.

Decomposition:
- Package div_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
  - the ALL_ONES helper constant.
- One combinational sub-module, div_step: inputs partial remainder, incoming bit and divisor; outputs next remainder and quotient bit.
- The FSM, counter and handshake logic live in div_int.

Test Plan (DATA_WIDTH=8):
- Normal: dividend 0x03E8 (1000), divisor 7, out_ready=1 → after 9 edges: quotient 142, remainder 6, flags 0; in_ready back to 1 the next cycle.
- Max legal: dividend 0xFEFF, divisor 0xFF → quotient 0xFF, remainder 0xFE, flags 0.
- Divide by zero: dividend 0x1234, divisor 0 → 1 edge later: quotient 0xFF, remainder 0x34, div_zero=1, overflow=0.
- Overflow: dividend 0x0800, divisor 0x08 → 1 edge later: quotient 0xFF, remainder 0, overflow=1.
- Back-pressure: run 1000/7 with out_ready low for 5 cycles after out_valid → outputs stable throughout. A new in_valid pulse during this window is not accepted. Result retires on the first out_ready high edge.
- Reset mid-op: assert rst_n low on the 4th BUSY cycle → out_valid=0 and outputs 0 immediately. After release, in_ready=1, and a fresh 100/3 gives quotient 33, remainder 1.
